// File: rtl/pipeline_stall_controller.sv
// ---------------------------------------------------------------------------
// pipeline_stall_controller
//
// Hazard/stall sequencer for a 5-stage in-order pipeline. In RUN the
// pipeline-control outputs respond combinationally to the hazard inputs in
// the same cycle (Mealy). Multi-cycle sequences use two waiting states:
// STALL for fixed-length branch-dependency stalls, and MD_WAIT for a
// multicycle mult/div, which a 6-bit watchdog guards.
//
// Ports
//   Clk            in   rising-edge clock
//   Reset          in   asynchronous, active-high; clears all state
//   LoadUseHazard  in   ID reads rt of a load in EX
//   BranchDepEX    in   branch in ID depends on the instruction in EX
//   BranchDepMEM   in   branch in ID depends on the instruction in MEM
//   ID_EXMemRead   in   instruction in EX is a load
//   BranchTaken    in   branch/jump in ID resolved taken
//   MulDivStart    in   multicycle mult/div issued from EX
//   MulDivDone     in   mult/div result ready this cycle
//   PCWrite        out  1 = PC updates
//   IF_IDWrite     out  1 = IF/ID register loads
//   ID_EXBubble    out  1 = zero ID/EX control fields
//   IF_IDFlush     out  1 = clear IF/ID to a nop
//   CtrlState      out  registered state: RUN=0, STALL=1, MD_WAIT=2
//   StallCycles    out  saturating count of cycles with PCWrite=0
//   MdTimeout      out  sticky mult/div watchdog-expired flag
// ---------------------------------------------------------------------------
module pipeline_stall_controller (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        LoadUseHazard,
  input  logic        BranchDepEX,
  input  logic        BranchDepMEM,
  input  logic        ID_EXMemRead,
  input  logic        BranchTaken,
  input  logic        MulDivStart,
  input  logic        MulDivDone,
  output logic        PCWrite,
  output logic        IF_IDWrite,
  output logic        ID_EXBubble,
  output logic        IF_IDFlush,
  output logic [1:0]  CtrlState,
  output logic [15:0] StallCycles,
  output logic        MdTimeout
);

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    STALL   = 2'd1,
    MD_WAIT = 2'd2,
    BAD     = 2'd3
  } state_t;

  // The watchdog value at which one more not-done cycle brings it to 63.
  // Counting the issue cycle, this gives 64 stall cycles before giving up.
  localparam logic [5:0]  WD_LAST = 6'd62;
  localparam logic [15:0] SC_MAX  = 16'hFFFF;

  state_t      state_r;
  state_t      state_next_s;
  logic [1:0]  remaining_r;
  logic [1:0]  remaining_next_s;
  logic [5:0]  watchdog_r;
  logic [5:0]  watchdog_next_s;
  logic [15:0] stall_cycles_r;
  logic        md_timeout_r;
  logic        timeout_set_s;
  logic        stall_s;
  logic        flush_s;

  assign CtrlState   = state_r;
  assign StallCycles = stall_cycles_r;
  assign MdTimeout   = md_timeout_r;

  // Next-state logic and the stall/flush decision for the current cycle.
  always_comb begin
    state_next_s     = state_r;
    remaining_next_s = remaining_r;
    watchdog_next_s  = watchdog_r;
    timeout_set_s    = 1'b0;
    stall_s          = 1'b0;
    flush_s          = 1'b0;
    case (state_r)
      RUN: begin
        // Only the highest-priority event present is serviced.
        if (MulDivStart) begin
          if (MulDivDone) begin
            state_next_s = RUN;
          end else begin
            stall_s         = 1'b1;
            state_next_s    = MD_WAIT;
            watchdog_next_s = 6'd0;
          end
        end else if (BranchDepEX) begin
          // Detect cycle is the first stall; Remaining counts the rest.
          stall_s          = 1'b1;
          remaining_next_s = ID_EXMemRead ? 2'd2 : 2'd1;
          state_next_s     = STALL;
        end else if (LoadUseHazard || BranchDepMEM) begin
          stall_s = 1'b1;
        end else if (BranchTaken) begin
          flush_s = 1'b1;
        end else begin
          flush_s = 1'b0;
        end
      end
      STALL: begin
        stall_s = 1'b1;
        if (remaining_r <= 2'd1) begin
          remaining_next_s = 2'd0;
          state_next_s     = RUN;
        end else begin
          remaining_next_s = remaining_r - 2'd1;
        end
      end
      MD_WAIT: begin
        if (MulDivDone) begin
          state_next_s    = RUN;
          watchdog_next_s = 6'd0;
        end else begin
          stall_s         = 1'b1;
          watchdog_next_s = watchdog_r + 6'd1;
          if (watchdog_r == WD_LAST) begin
            timeout_set_s = 1'b1;
            state_next_s  = RUN;
          end else begin
            state_next_s = MD_WAIT;
          end
        end
      end
      default: begin
        // Illegal encoding: hold the pipeline for one cycle and recover.
        stall_s          = 1'b1;
        state_next_s     = RUN;
        remaining_next_s = 2'd0;
        watchdog_next_s  = 6'd0;
      end
    endcase
  end

  // Pipeline-control outputs; Reset forces the stall set combinationally.
  always_comb begin
    if (Reset) begin
      PCWrite     = 1'b0;
      IF_IDWrite  = 1'b0;
      ID_EXBubble = 1'b1;
      IF_IDFlush  = 1'b0;
    end else begin
      PCWrite     = ~stall_s;
      IF_IDWrite  = ~stall_s;
      ID_EXBubble = stall_s;
      IF_IDFlush  = flush_s;
    end
  end

  // State, counters and the sticky timeout flag.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_r        <= RUN;
      remaining_r    <= 2'd0;
      watchdog_r     <= 6'd0;
      stall_cycles_r <= 16'd0;
      md_timeout_r   <= 1'b0;
    end else begin
      state_r     <= state_next_s;
      remaining_r <= remaining_next_s;
      watchdog_r  <= watchdog_next_s;
      if (timeout_set_s) begin
        md_timeout_r <= 1'b1;
      end
      if (stall_s && (stall_cycles_r != SC_MAX)) begin
        stall_cycles_r <= stall_cycles_r + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_pipeline_stall_controller.sv
module tb_pipeline_stall_controller;

  logic        Clk;
  logic        Reset;
  logic        LoadUseHazard;
  logic        BranchDepEX;
  logic        BranchDepMEM;
  logic        ID_EXMemRead;
  logic        BranchTaken;
  logic        MulDivStart;
  logic        MulDivDone;
  logic        PCWrite;
  logic        IF_IDWrite;
  logic        ID_EXBubble;
  logic        IF_IDFlush;
  logic [1:0]  CtrlState;
  logic [15:0] StallCycles;
  logic        MdTimeout;

  int n_checks = 0;
  int n_pass   = 0;

  pipeline_stall_controller dut (
    .Clk(Clk), .Reset(Reset),
    .LoadUseHazard(LoadUseHazard), .BranchDepEX(BranchDepEX),
    .BranchDepMEM(BranchDepMEM), .ID_EXMemRead(ID_EXMemRead),
    .BranchTaken(BranchTaken), .MulDivStart(MulDivStart),
    .MulDivDone(MulDivDone), .PCWrite(PCWrite), .IF_IDWrite(IF_IDWrite),
    .ID_EXBubble(ID_EXBubble), .IF_IDFlush(IF_IDFlush),
    .CtrlState(CtrlState), .StallCycles(StallCycles), .MdTimeout(MdTimeout)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

  task automatic clear_in();
    LoadUseHazard = 1'b0; BranchDepEX = 1'b0; BranchDepMEM = 1'b0;
    ID_EXMemRead = 1'b0; BranchTaken = 1'b0; MulDivStart = 1'b0;
    MulDivDone = 1'b0;
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are sampled 2 later.
  task automatic next_cycle();
    @(posedge Clk);
    #1;
  endtask

  task automatic do_reset();
    clear_in();
    Reset = 1'b1;
    next_cycle();
    next_cycle();
    Reset = 1'b0;
  endtask

  task automatic test_reset();
    Reset = 1'b1; LoadUseHazard = 1'b1; BranchTaken = 1'b1;
    next_cycle(); #2;
    n_checks++; if (PCWrite !== 1'b0) $display("FAIL rst_pc: got %b expected 0", PCWrite); else n_pass++;
    n_checks++; if (IF_IDWrite !== 1'b0) $display("FAIL rst_ifid: got %b expected 0", IF_IDWrite); else n_pass++;
    n_checks++; if (ID_EXBubble !== 1'b1) $display("FAIL rst_bubble: got %b expected 1", ID_EXBubble); else n_pass++;
    n_checks++; if (IF_IDFlush !== 1'b0) $display("FAIL rst_flush: got %b expected 0", IF_IDFlush); else n_pass++;
    n_checks++; if (CtrlState !== 2'd0) $display("FAIL rst_state: got %0d expected 0", CtrlState); else n_pass++;
    n_checks++; if (StallCycles !== 16'd0) $display("FAIL rst_sc: got %0d expected 0", StallCycles); else n_pass++;
    n_checks++; if (MdTimeout !== 1'b0) $display("FAIL rst_to: got %b expected 0", MdTimeout); else n_pass++;
    next_cycle();
    clear_in(); Reset = 1'b0; #2;
    n_checks++; if (PCWrite !== 1'b1) $display("FAIL rst_release_pc: got %b expected 1", PCWrite); else n_pass++;
    next_cycle();
  endtask

  task automatic test_load_use();
    do_reset();
    LoadUseHazard = 1'b1; #2;
    n_checks++; if (PCWrite !== 1'b0) $display("FAIL lu_pc: got %b expected 0", PCWrite); else n_pass++;
    n_checks++; if (ID_EXBubble !== 1'b1) $display("FAIL lu_bubble: got %b expected 1", ID_EXBubble); else n_pass++;
    next_cycle(); clear_in(); #2;
    n_checks++; if (PCWrite !== 1'b1) $display("FAIL lu_after_pc: got %b expected 1", PCWrite); else n_pass++;
    n_checks++; if (CtrlState !== 2'd0) $display("FAIL lu_state: got %0d expected 0", CtrlState); else n_pass++;
    n_checks++; if (StallCycles !== 16'd1) $display("FAIL lu_sc: got %0d expected 1", StallCycles); else n_pass++;
    next_cycle(); BranchDepMEM = 1'b1; #2;
    n_checks++; if (PCWrite !== 1'b0) $display("FAIL bmem_pc: got %b expected 0", PCWrite); else n_pass++;
    next_cycle(); clear_in(); #2;
    n_checks++; if (PCWrite !== 1'b1) $display("FAIL bmem_after_pc: got %b expected 1", PCWrite); else n_pass++;
    n_checks++; if (StallCycles !== 16'd2) $display("FAIL bmem_sc: got %0d expected 2", StallCycles); else n_pass++;
    next_cycle();
  endtask

  task automatic test_branch_dep_ex();
    logic       pcs [5];
    logic [1:0] sts [5];
    logic       fls [5];
    logic       exp_pc [5];
    logic [1:0] exp_st [5];
    // Load in EX: three stall cycles; BranchTaken during the stall is ignored.
    exp_pc = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    exp_st = '{2'd0, 2'd1, 2'd1, 2'd0, 2'd0};
    do_reset();
    BranchDepEX = 1'b1; ID_EXMemRead = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #2; pcs[i] = PCWrite; sts[i] = CtrlState; fls[i] = IF_IDFlush;
      next_cycle(); clear_in(); BranchTaken = (i < 2);
    end
    for (int i = 0; i < 5; i++) begin
      n_checks++; if (pcs[i] !== exp_pc[i]) $display("FAIL bex3_pc[%0d]: got %b expected %b", i, pcs[i], exp_pc[i]); else n_pass++;
      n_checks++; if (sts[i] !== exp_st[i]) $display("FAIL bex3_state[%0d]: got %0d expected %0d", i, sts[i], exp_st[i]); else n_pass++;
      n_checks++; if (fls[i] !== 1'b0) $display("FAIL bex3_flush[%0d]: got %b expected 0", i, fls[i]); else n_pass++;
    end
    n_checks++; if (StallCycles !== 16'd3) $display("FAIL bex3_sc: got %0d expected 3", StallCycles); else n_pass++;
    // Non-load in EX: two stall cycles.
    exp_pc = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    exp_st = '{2'd0, 2'd1, 2'd0, 2'd0, 2'd0};
    do_reset();
    BranchDepEX = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #2; pcs[i] = PCWrite; sts[i] = CtrlState;
      next_cycle(); clear_in();
    end
    for (int i = 0; i < 4; i++) begin
      n_checks++; if (pcs[i] !== exp_pc[i]) $display("FAIL bex2_pc[%0d]: got %b expected %b", i, pcs[i], exp_pc[i]); else n_pass++;
      n_checks++; if (sts[i] !== exp_st[i]) $display("FAIL bex2_state[%0d]: got %0d expected %0d", i, sts[i], exp_st[i]); else n_pass++;
    end
    n_checks++; if (StallCycles !== 16'd2) $display("FAIL bex2_sc: got %0d expected 2", StallCycles); else n_pass++;
  endtask

  task automatic test_muldiv();
    logic exp_pc;
    do_reset();
    MulDivStart = 1'b1; #2;
    n_checks++; if (PCWrite !== 1'b0) $display("FAIL md_issue_pc: got %b expected 0", PCWrite); else n_pass++;
    next_cycle(); clear_in();
    for (int k = 1; k <= 5; k++) begin
      MulDivDone = (k == 5); #2;
      exp_pc = (k == 5);
      n_checks++; if (CtrlState !== 2'd2) $display("FAIL md_state[%0d]: got %0d expected 2", k, CtrlState); else n_pass++;
      n_checks++; if (PCWrite !== exp_pc) $display("FAIL md_pc[%0d]: got %b expected %b", k, PCWrite, exp_pc); else n_pass++;
      next_cycle();
    end
    clear_in(); #2;
    n_checks++; if (CtrlState !== 2'd0) $display("FAIL md_back_state: got %0d expected 0", CtrlState); else n_pass++;
    n_checks++; if (StallCycles !== 16'd5) $display("FAIL md_sc: got %0d expected 5", StallCycles); else n_pass++;
    // Start and Done together: no stall, stays in RUN.
    MulDivStart = 1'b1; MulDivDone = 1'b1; #2;
    n_checks++; if (PCWrite !== 1'b1) $display("FAIL md_same_pc: got %b expected 1", PCWrite); else n_pass++;
    next_cycle(); clear_in(); #2;
    n_checks++; if (CtrlState !== 2'd0) $display("FAIL md_same_state: got %0d expected 0", CtrlState); else n_pass++;
    n_checks++; if (StallCycles !== 16'd5) $display("FAIL md_same_sc: got %0d expected 5", StallCycles); else n_pass++;
    next_cycle();
  endtask

  task automatic test_md_timeout();
    int stalls = 0;
    int early  = 0;
    do_reset();
    MulDivStart = 1'b1; #2;
    while (PCWrite === 1'b0 && stalls < 200) begin
      stalls++;
      if (MdTimeout !== 1'b0) early++;
      next_cycle(); MulDivStart = 1'b0; #2;
    end
    n_checks++; if (stalls != 64) $display("FAIL mdto_stalls: got %0d expected 64", stalls); else n_pass++;
    n_checks++; if (early != 0) $display("FAIL mdto_early: got %0d cycles with flag set expected 0", early); else n_pass++;
    n_checks++; if (MdTimeout !== 1'b1) $display("FAIL mdto_flag: got %b expected 1", MdTimeout); else n_pass++;
    n_checks++; if (CtrlState !== 2'd0) $display("FAIL mdto_state: got %0d expected 0", CtrlState); else n_pass++;
    MulDivStart = 1'b1; MulDivDone = 1'b1;
    next_cycle(); clear_in(); LoadUseHazard = 1'b1;
    next_cycle(); clear_in(); #2;
    n_checks++; if (MdTimeout !== 1'b1) $display("FAIL mdto_sticky: got %b expected 1", MdTimeout); else n_pass++;
    do_reset(); #2;
    n_checks++; if (MdTimeout !== 1'b0) $display("FAIL mdto_clear: got %b expected 0", MdTimeout); else n_pass++;
    next_cycle();
  endtask

  task automatic test_branch_flush();
    do_reset();
    BranchTaken = 1'b1; LoadUseHazard = 1'b1; #2;
    n_checks++; if (PCWrite !== 1'b0) $display("FAIL bt_lu_pc: got %b expected 0", PCWrite); else n_pass++;
    n_checks++; if (IF_IDFlush !== 1'b0) $display("FAIL bt_lu_flush: got %b expected 0", IF_IDFlush); else n_pass++;
    next_cycle(); LoadUseHazard = 1'b0; #2;
    n_checks++; if (IF_IDFlush !== 1'b1) $display("FAIL bt_flush: got %b expected 1", IF_IDFlush); else n_pass++;
    n_checks++; if (PCWrite !== 1'b1) $display("FAIL bt_pc: got %b expected 1", PCWrite); else n_pass++;
    n_checks++; if (ID_EXBubble !== 1'b0) $display("FAIL bt_bubble: got %b expected 0", ID_EXBubble); else n_pass++;
    next_cycle(); clear_in(); #2;
    n_checks++; if (IF_IDFlush !== 1'b0) $display("FAIL bt_after_flush: got %b expected 0", IF_IDFlush); else n_pass++;
    next_cycle();
  endtask

  task automatic test_reset_mid_seq();
    do_reset();
    BranchDepEX = 1'b1; ID_EXMemRead = 1'b1;
    next_cycle(); clear_in(); #2;
    n_checks++; if (CtrlState !== 2'd1) $display("FAIL rms_in_stall: got %0d expected 1", CtrlState); else n_pass++;
    Reset = 1'b1; #1;
    n_checks++; if (CtrlState !== 2'd0) $display("FAIL rms_state: got %0d expected 0", CtrlState); else n_pass++;
    n_checks++; if (StallCycles !== 16'd0) $display("FAIL rms_sc: got %0d expected 0", StallCycles); else n_pass++;
    next_cycle(); Reset = 1'b0; #2;
    n_checks++; if (PCWrite !== 1'b1) $display("FAIL rms_first_pc: got %b expected 1", PCWrite); else n_pass++;
    next_cycle(); #2;
    n_checks++; if (PCWrite !== 1'b1) $display("FAIL rms_second_pc: got %b expected 1", PCWrite); else n_pass++;
    MulDivStart = 1'b1;
    next_cycle(); clear_in(); #2;
    n_checks++; if (CtrlState !== 2'd2) $display("FAIL rmd_in_wait: got %0d expected 2", CtrlState); else n_pass++;
    Reset = 1'b1; #1;
    n_checks++; if (CtrlState !== 2'd0) $display("FAIL rmd_state: got %0d expected 0", CtrlState); else n_pass++;
    next_cycle(); Reset = 1'b0; #2;
    n_checks++; if (PCWrite !== 1'b1) $display("FAIL rmd_first_pc: got %b expected 1", PCWrite); else n_pass++;
    next_cycle(); #2;
    n_checks++; if (CtrlState !== 2'd0) $display("FAIL rmd_second_state: got %0d expected 0", CtrlState); else n_pass++;
    next_cycle();
  endtask

  // Randomized run against a cycle-level model built from the stall rules:
  // a count of fixed stall cycles still owed, and a mult/div wait with a
  // count of not-done cycles (63 of them means give up).
  task automatic test_random();
    int   m_left = 0;
    int   m_cnt  = 0;
    bit   m_md   = 1'b0;
    bit   m_to   = 1'b0;
    int   m_sc   = 0;
    bit   rst, e_stall, e_fl, e_to;
    int   e_state, e_sc;
    do_reset();
    for (int c = 0; c < 1500; c++) begin
      rst = ($urandom_range(199) == 0);
      clear_in();
      MulDivStart = ($urandom_range(7) == 0);
      if (!MulDivStart) begin
        LoadUseHazard = ($urandom_range(5) == 0);
        BranchDepEX   = ($urandom_range(7) == 0);
        BranchDepMEM  = ($urandom_range(7) == 0);
        BranchTaken   = ($urandom_range(3) == 0);
      end
      ID_EXMemRead = $urandom_range(1);
      MulDivDone   = (c < 700) ? ($urandom_range(5) == 0) : ($urandom_range(79) == 0);
      Reset = rst;
      #2;
      e_fl = 1'b0;
      if (rst) begin
        m_left = 0; m_cnt = 0; m_md = 1'b0; m_to = 1'b0; m_sc = 0;
        e_state = 0; e_sc = 0; e_to = 1'b0; e_stall = 1'b1;
      end else begin
        e_state = m_md ? 2 : ((m_left > 0) ? 1 : 0);
        e_sc = m_sc; e_to = m_to;
        if (m_md) begin
          e_stall = !MulDivDone;
          if (MulDivDone) m_md = 1'b0;
          else begin
            m_cnt++;
            if (m_cnt == 63) begin m_to = 1'b1; m_md = 1'b0; end
          end
        end else if (m_left > 0) begin
          e_stall = 1'b1; m_left--;
        end else if (MulDivStart) begin
          e_stall = !MulDivDone;
          if (!MulDivDone) begin m_md = 1'b1; m_cnt = 0; end
        end else if (BranchDepEX) begin
          e_stall = 1'b1; m_left = ID_EXMemRead ? 2 : 1;
        end else if (LoadUseHazard || BranchDepMEM) begin
          e_stall = 1'b1;
        end else begin
          e_stall = 1'b0; e_fl = BranchTaken;
        end
        if (e_stall && m_sc < 65535) m_sc++;
      end
      n_checks++; if (PCWrite !== !e_stall) $display("FAIL rnd_pc c=%0d: got %b expected %b", c, PCWrite, !e_stall); else n_pass++;
      n_checks++; if (IF_IDWrite !== !e_stall) $display("FAIL rnd_ifid c=%0d: got %b expected %b", c, IF_IDWrite, !e_stall); else n_pass++;
      n_checks++; if (ID_EXBubble !== e_stall) $display("FAIL rnd_bubble c=%0d: got %b expected %b", c, ID_EXBubble, e_stall); else n_pass++;
      n_checks++; if (IF_IDFlush !== e_fl) $display("FAIL rnd_flush c=%0d: got %b expected %b", c, IF_IDFlush, e_fl); else n_pass++;
      n_checks++; if (CtrlState !== e_state[1:0]) $display("FAIL rnd_state c=%0d: got %0d expected %0d", c, CtrlState, e_state); else n_pass++;
      n_checks++; if (StallCycles !== e_sc[15:0]) $display("FAIL rnd_sc c=%0d: got %0d expected %0d", c, StallCycles, e_sc); else n_pass++;
      n_checks++; if (MdTimeout !== e_to) $display("FAIL rnd_to c=%0d: got %b expected %b", c, MdTimeout, e_to); else n_pass++;
      next_cycle();
    end
    Reset = 1'b0;
    clear_in();
  endtask

  initial begin
    Reset = 1'b1;
    clear_in();
    test_reset();
    test_load_use();
    test_branch_dep_ex();
    test_muldiv();
    test_md_timeout();
    test_branch_flush();
    test_reset_mid_seq();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
